keypad_scan: RTL and testbench

//   4x4 matrix-keypad scanner: the input-side counterpart of the multiplexed 7-seg display driver.

---
 rtl/keypad_scan_pkg.sv | 51 +++++
 rtl/keypad_scan_tick_gen.sv | 41 ++++
 rtl/keypad_scan.sv | 236 +++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg
//   Shared constants and small pure helpers for the 4x4 keypad scanner.
//   FSM state encodings, the row-drive reset pattern, the idle column pattern
//   and the one-cold <-> index conversions used by the scanner top.
//   Optional feature macro used by the scanner: KEYPAD_REPEAT_EN.
package keypad_scan_pkg;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;

    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_IDLE  = 4'b1111;

    // True when exactly one of the four active-low lines is asserted.
    function automatic logic single_low(input logic [3:0] v);
        logic r;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Index of the single low line; only meaningful when single_low(v) holds.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Column pattern expected while the key at column idx is pressed.
    function automatic logic [3:0] low_pattern(input logic [1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = 4'b1110;
            2'd1:    r = 4'b1101;
            2'd2:    r = 4'b1011;
            2'd3:    r = 4'b0111;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// scan_tick_gen
//   Divides the system clock down to the keypad scan/sample rate.
//   Ports:
//     clk_100Mhz  in   system clock
//     rst_n       in   asynchronous reset, active-low
//     tick        out  registered one-cycle strobe every DIV clock cycles
module scan_tick_gen
    import keypad_scan_pkg::*;
#(
    parameter int DIV = 100_000
) (
    input  logic clk_100Mhz,
    input  logic rst_n,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);
    localparam logic [CW-1:0]   ZERO = CW'(0);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Free-running divider; the strobe is registered so it is glitch-free.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= ZERO;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= ZERO;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + ONE;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
//   4x4 matrix-keypad scanner. Drives one active-low row at a time, samples
//   the active-low columns through a 2-flop synchronizer, debounces press and
//   release, rejects ghost patterns (two or more columns low) and emits one
//   key code per accepted press.
//   Optional feature: define KEYPAD_REPEAT_EN to get auto-repeat pulses while
//   a key stays held (first after REPEAT_DELAY ticks, then every REPEAT_PERIOD).
//   Ports:
//     clk_100Mhz  in   system clock
//     rst_n       in   asynchronous reset, active-low
//     col[3:0]    in   keypad columns, active-low, asynchronous
//     row[3:0]    out  row drive, active-low, exactly one bit low
//     key_code    out  {row_idx, col_idx} of last accepted key
//     key_valid   out  one-cycle pulse when key_code is newly valid
//     key_held    out  high while the accepted key is still pressed
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic       clk_100Mhz,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int            DW       = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [DW-1:0] DEB_ZERO = DW'(0);

    if (DEBOUNCE_TICKS < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || CLK_HZ < SCAN_HZ) begin : g_param_check
        $error("keypad_scan: unsupported parameter set");
    end

    logic          tick_s;
    logic [3:0]    col_meta_r, col_sync_r;
    logic [1:0]    state_r, state_nx;
    logic [3:0]    row_r, row_nx;
    logic [1:0]    lat_row_r, lat_row_nx;
    logic [1:0]    lat_col_r, lat_col_nx;
    logic [DW-1:0] deb_cnt_r, deb_nx, deb_inc_s;
    logic [DW-1:0] rel_cnt_r, rel_nx, rel_inc_s;
    logic [3:0]    key_code_r, code_nx;
    logic          key_valid_r, valid_nx;
    logic          key_held_r, held_nx;
    logic          rep_fire_s;

    scan_tick_gen #(
        .DIV (CLK_HZ / SCAN_HZ)
    ) u_tick (
        .clk_100Mhz (clk_100Mhz),
        .rst_n      (rst_n),
        .tick       (tick_s)
    );

    // Synchronize the asynchronous column inputs; idle (all high) out of reset.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_r <= COL_IDLE;
            col_sync_r <= COL_IDLE;
        end else begin
            col_meta_r <= col;
            col_sync_r <= col_meta_r;
        end
    end

    assign deb_inc_s = (deb_cnt_r == DEB_MAX) ? deb_cnt_r : deb_cnt_r + DEB_ONE;
    assign rel_inc_s = (rel_cnt_r == DEB_MAX) ? rel_cnt_r : rel_cnt_r + DEB_ONE;

`ifdef KEYPAD_REPEAT_EN
    localparam int             REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             RW       = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0]  REP_MAXV = RW'(REP_MAX);
    localparam logic [RW-1:0]  REP_DLY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0]  REP_PER  = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0]  REP_ONE  = RW'(1);
    localparam logic [RW-1:0]  REP_ZERO = RW'(0);

    logic [RW-1:0] rep_cnt_r, rep_cnt_nx, rep_inc_s;
    logic          rep_armed_r, rep_armed_nx;

    assign rep_inc_s = (rep_cnt_r == REP_MAXV) ? rep_cnt_r : rep_cnt_r + REP_ONE;

    // Auto-repeat timing: first pulse after the initial delay, then periodic.
    // Any all-high tick in HOLD (release starting) cancels and restarts timing.
    always_comb begin
        rep_cnt_nx   = rep_cnt_r;
        rep_armed_nx = rep_armed_r;
        rep_fire_s   = 1'b0;
        if (state_r != HOLD) begin
            rep_cnt_nx   = REP_ZERO;
            rep_armed_nx = 1'b0;
        end else if (tick_s) begin
            if (col_sync_r == COL_IDLE) begin
                rep_cnt_nx   = REP_ZERO;
                rep_armed_nx = 1'b0;
            end else if (!rep_armed_r && rep_inc_s >= REP_DLY) begin
                rep_fire_s   = 1'b1;
                rep_cnt_nx   = REP_ZERO;
                rep_armed_nx = 1'b1;
            end else if (rep_armed_r && rep_inc_s >= REP_PER) begin
                rep_fire_s   = 1'b1;
                rep_cnt_nx   = REP_ZERO;
            end else begin
                rep_cnt_nx   = rep_inc_s;
            end
        end else begin
            rep_cnt_nx   = rep_cnt_r;
        end
    end

    // Repeat counter state.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r   <= REP_ZERO;
            rep_armed_r <= 1'b0;
        end else begin
            rep_cnt_r   <= rep_cnt_nx;
            rep_armed_r <= rep_armed_nx;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Scan / debounce / hold decisions, all taken on the sample tick.
    always_comb begin
        state_nx   = state_r;
        row_nx     = row_r;
        lat_row_nx = lat_row_r;
        lat_col_nx = lat_col_r;
        deb_nx     = deb_cnt_r;
        rel_nx     = rel_cnt_r;
        code_nx    = key_code_r;
        valid_nx   = 1'b0;
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    // Exactly one low column on the driven row is a candidate;
                    // all-high or multiple lows (ghosting) keep the scan moving.
                    if (single_low(col_sync_r)) begin
                        lat_row_nx = low_index(row_r);
                        lat_col_nx = low_index(col_sync_r);
                        deb_nx     = DEB_ONE;
                        rel_nx     = DEB_ZERO;
                        state_nx   = DEBOUNCE;
                    end else begin
                        row_nx     = {row_r[2:0], row_r[3]};
                        deb_nx     = DEB_ZERO;
                    end
                end
                DEBOUNCE: begin
                    if (col_sync_r == low_pattern(lat_col_r)) begin
                        if (deb_inc_s >= DEB_MAX) begin
                            code_nx  = {lat_row_r, lat_col_r};
                            valid_nx = 1'b1;
                            deb_nx   = DEB_ZERO;
                            rel_nx   = DEB_ZERO;
                            state_nx = HOLD;
                        end else begin
                            deb_nx   = deb_inc_s;
                        end
                    end else begin
                        // Row stays put here and resumes rotating on the next tick.
                        deb_nx   = DEB_ZERO;
                        state_nx = SCAN;
                    end
                end
                HOLD: begin
                    // Release needs every column high; a second key is ignored.
                    if (col_sync_r == COL_IDLE) begin
                        if (rel_inc_s >= DEB_MAX) begin
                            rel_nx   = DEB_ZERO;
                            state_nx = SCAN;
                        end else begin
                            rel_nx   = rel_inc_s;
                        end
                    end else begin
                        rel_nx   = DEB_ZERO;
                        valid_nx = rep_fire_s;
                    end
                end
                default: begin
                    state_nx = SCAN;
                    row_nx   = ROW_RESET;
                    deb_nx   = DEB_ZERO;
                    rel_nx   = DEB_ZERO;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // key_held follows HOLD one cycle after acceptance and drops as HOLD is left.
    assign held_nx = (state_r == HOLD) && (state_nx == HOLD);

    // Main state and registered outputs.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SCAN;
            row_r       <= ROW_RESET;
            lat_row_r   <= 2'd0;
            lat_col_r   <= 2'd0;
            deb_cnt_r   <= DEB_ZERO;
            rel_cnt_r   <= DEB_ZERO;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_nx;
            row_r       <= row_nx;
            lat_row_r   <= lat_row_nx;
            lat_col_r   <= lat_col_nx;
            deb_cnt_r   <= deb_nx;
            rel_cnt_r   <= rel_nx;
            key_code_r  <= code_nx;
            key_valid_r <= valid_nx;
            key_held_r  <= held_nx;
        end
    end

    assign row       = row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
//   Directed bench for keypad_scan with a small keypad model: the modelled key
//   sits at row 2 / column 1, so its code is 4'b1001. Tick every 10 cycles,
//   3 debounce ticks, repeat delay 5 ticks and period 2 ticks.
module tb_keypad_scan;

    logic       clk_100Mhz = 1'b0;
    logic       rst_n      = 1'b0;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    bit double_pulse = 1'b0;
    logic prev_valid = 1'b0;
    int pulse_t[$];
    int key_mode = 0;   // 0 none, 1 key (r2,c1), 2 ghost (r2,c1+c2)

    keypad_scan #(
        .CLK_HZ         (1000),
        .SCAN_HZ        (100),
        .DEBOUNCE_TICKS (3),
        .REPEAT_DELAY   (5),
        .REPEAT_PERIOD  (2)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .rst_n      (rst_n),
        .col        (col),
        .row        (row),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    // Keypad model: column lines reflect the pressed key only on its driven row.
    always_comb begin
        col = 4'b1111;
        if (row[2] == 1'b0) begin
            if (key_mode == 1)      col = 4'b1101;
            else if (key_mode == 2) col = 4'b1001;
        end
    end

    always @(posedge clk_100Mhz) cyc <= cyc + 1;

    // Pulse monitor.
    always @(negedge clk_100Mhz) begin
        if (key_valid === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_t.push_back(cyc);
            if (prev_valid === 1'b1) double_pulse <= 1'b1;
        end
        prev_valid <= key_valid;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        key_mode = 0;
        repeat (3) @(negedge clk_100Mhz);
        n_cmp++; if (row !== 4'b1110) begin n_bad++; $display("FAIL reset_row: got %b want 1110", row); end
        n_cmp++; if (key_code !== 4'b0000) begin n_bad++; $display("FAIL reset_code: got %b want 0000", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_held: got %b want 0", key_held); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_row;
        logic [3:0] prev;
        int k;
        int p0;
        key_mode = 0;
        p0 = pulse_cnt;
        exp_row = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            prev = exp_row;
            exp_row = {exp_row[2:0], exp_row[3]};
            k = 0;
            while (row === prev && k < 25) begin
                @(negedge clk_100Mhz);
                k++;
            end
            n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL idle_rotate[%0d]: got %b want %b", i, row, exp_row); end
            if (i > 0) begin
                n_cmp++; if (k !== 10) begin n_bad++; $display("FAIL idle_period[%0d]: got %0d cycles want 10", i, k); end
            end
        end
        #1;
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL idle_no_pulse: got %0d pulses want 0", pulse_cnt - p0); end
    endtask

    task automatic wait_release(input string tag);
        int k;
        k = 0;
        while (key_held !== 1'b0 && k < 60) begin
            @(negedge clk_100Mhz);
            k++;
        end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL %s_release: key_held=%b want 0 within 60 cycles", tag, key_held); end
    endtask

    task automatic test_single_press();
        int k;
        int p0;
        p0 = pulse_cnt;
        key_mode = 1;
        k = 0;
        while (key_valid !== 1'b1 && k < 200) begin
            @(negedge clk_100Mhz);
            k++;
        end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL press_pulse: key_valid=%b want 1 within 200 cycles", key_valid); end
        n_cmp++; if (key_code !== 4'b1001) begin n_bad++; $display("FAIL press_code: got %b want 1001", key_code); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL press_held_lag: got %b want 0 on pulse cycle", key_held); end
        @(negedge clk_100Mhz);
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL press_held: got %b want 1", key_held); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_pulse_width: got %b want 0", key_valid); end
        repeat (40) @(negedge clk_100Mhz);
        #1;
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL press_one_pulse: got %0d want 1", pulse_cnt - p0); end
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL press_still_held: got %b want 1", key_held); end
        key_mode = 0;
        repeat (15) @(negedge clk_100Mhz);
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL release_debounce: key_held=%b want 1 after 15 cycles", key_held); end
        repeat (25) @(negedge clk_100Mhz);
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL release_done: key_held=%b want 0 after 40 cycles", key_held); end
        n_cmp++; if (key_code !== 4'b1001) begin n_bad++; $display("FAIL release_code_kept: got %b want 1001", key_code); end
        #1;
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL release_no_pulse: got %0d want 1", pulse_cnt - p0); end
    endtask

    task automatic test_bounce();
        int k;
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            key_mode = (i % 2 == 0) ? 1 : 0;
            repeat (7) @(negedge clk_100Mhz);
        end
        #1;
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL bounce_no_early: got %0d pulses want 0", pulse_cnt - p0); end
        key_mode = 1;
        k = 0;
        while (key_valid !== 1'b1 && k < 150) begin
            @(negedge clk_100Mhz);
            k++;
        end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL bounce_pulse: key_valid=%b want 1 within 150 cycles", key_valid); end
        n_cmp++; if (k < 20) begin n_bad++; $display("FAIL bounce_settle: pulse after %0d stable cycles want >= 20", k); end
        n_cmp++; if (key_code !== 4'b1001) begin n_bad++; $display("FAIL bounce_code: got %b want 1001", key_code); end
        repeat (40) @(negedge clk_100Mhz);
        #1;
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL bounce_one_pulse: got %0d want 1", pulse_cnt - p0); end
        key_mode = 0;
        wait_release("bounce");
    endtask

    task automatic test_ghost();
        int p0;
        int changes;
        logic [3:0] prev;
        key_mode = 2;
        p0 = pulse_cnt;
        changes = 0;
        @(negedge clk_100Mhz);
        prev = row;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100Mhz);
            if (row !== prev) changes++;
            prev = row;
        end
        #1;
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL ghost_no_pulse: got %0d pulses want 0", pulse_cnt - p0); end
        n_cmp++; if (changes !== 10) begin n_bad++; $display("FAIL ghost_rotate: got %0d row steps want 10", changes); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL ghost_held: got %b want 0", key_held); end
        key_mode = 0;
    endtask

    task automatic test_reset_in_hold();
        int k;
        int p0;
        key_mode = 1;
        k = 0;
        while (key_held !== 1'b1 && k < 200) begin
            @(negedge clk_100Mhz);
            k++;
        end
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL rst_hold_enter: key_held=%b want 1 within 200 cycles", key_held); end
        repeat (3) @(negedge clk_100Mhz);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (row !== 4'b1110) begin n_bad++; $display("FAIL rst_hold_row: got %b want 1110", row); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL rst_hold_held: got %b want 0", key_held); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_hold_valid: got %b want 0", key_valid); end
        n_cmp++; if (key_code !== 4'b0000) begin n_bad++; $display("FAIL rst_hold_code: got %b want 0000", key_code); end
        key_mode = 0;
        repeat (3) @(negedge clk_100Mhz);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        repeat (100) @(negedge clk_100Mhz);
        #1;
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL rst_release_pulse: got %0d pulses want 0", pulse_cnt - p0); end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int k;
        int n0;
        int gap;
        n0 = pulse_t.size();
        key_mode = 1;
        k = 0;
        while (key_valid !== 1'b1 && k < 200) begin
            @(negedge clk_100Mhz);
            k++;
        end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL repeat_first: key_valid=%b want 1 within 200 cycles", key_valid); end
        repeat (120) @(negedge clk_100Mhz);
        #1;
        n_cmp++; if (pulse_t.size() - n0 !== 5) begin n_bad++; $display("FAIL repeat_count: got %0d pulses want 5", pulse_t.size() - n0); end
        for (int i = 1; i < 5; i++) begin
            if (n0 + i < pulse_t.size()) begin
                gap = pulse_t[n0 + i] - pulse_t[n0 + i - 1];
                n_cmp++;
                if (gap !== ((i == 1) ? 50 : 20)) begin
                    n_bad++; $display("FAIL repeat_gap[%0d]: got %0d cycles want %0d", i, gap, (i == 1) ? 50 : 20);
                end
            end
        end
        n0 = pulse_t.size();
        key_mode = 0;
        repeat (60) @(negedge clk_100Mhz);
        #1;
        n_cmp++; if (pulse_t.size() !== n0) begin n_bad++; $display("FAIL repeat_after_release: got %0d pulses want 0", pulse_t.size() - n0); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL repeat_release_held: got %b want 0", key_held); end
    endtask
`endif

    task automatic test_valid_width();
        #1;
        n_cmp++; if (double_pulse !== 1'b0) begin n_bad++; $display("FAIL valid_width: key_valid high on consecutive cycles"); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press();
        test_bounce();
        test_ghost();
        test_reset_in_hold();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        test_valid_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
